// File: rtl/round_robin_arbiter_param_slicing.sv
// rtl/round_robin_arbiter_param_slicing.sv - round-robin arbiter granting each requester a programmable time slice
// Two-state FSM; a grant lasts SLICE_LEN[i] cycles (0 treated as 1) unless released early.
module round_robin_arbiter_param_slicing #(
   parameter int N       = 4,
   parameter int SLICE_W = 4,
   localparam int ID_W   = (N > 1) ? $clog2(N) : 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N-1:0]           REQ,
   input  logic [N*SLICE_W-1:0]   SLICE_LEN,
   output logic [N-1:0]           GNT,
   output logic [ID_W-1:0]        GNT_ID,
   output logic                   GNT_VLD,
   output logic [SLICE_W-1:0]     SLICE_LEFT
);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t             state_q;
   logic [ID_W-1:0]    ptr_q;
   logic [N-1:0]       gnt_q;
   logic [ID_W-1:0]    gnt_id_q;
   logic               gnt_vld_q;
   logic [SLICE_W-1:0] slice_left_q;

   logic               found;
   logic [ID_W-1:0]    pick_id;
   logic [ID_W-1:0]    cand;
   logic [SLICE_W-1:0] len_fld [N];
   logic [SLICE_W-1:0] pick_len;
   logic               search;

   logic [N-1:0]       gnt_d;
   logic [ID_W-1:0]    ptr_d;
   logic [SLICE_W-1:0] slice_left_d;

   for (genvar g = 0; g < N; g++) begin : g_len
      assign len_fld[g] = SLICE_LEN[g*SLICE_W +: SLICE_W];
   end

   // First requester at or above ptr_q, wrapping N-1 -> 0.
   always_comb begin
      int idx;
      idx     = 0;
      cand    = '0;
      found   = 1'b0;
      pick_id = '0;
      for (int k = 0; k < N; k++) begin
         idx = int'(ptr_q) + k;
         if (idx >= N) begin
            idx = idx - N;
         end
         cand = ID_W'(idx);
         if (!found && REQ[cand]) begin
            found   = 1'b1;
            pick_id = cand;
         end
      end
   end

   assign pick_len     = len_fld[pick_id];
   assign slice_left_d = (pick_len == '0) ? SLICE_W'(1) : pick_len;
   assign gnt_d        = N'(1) << pick_id;
   assign ptr_d        = (pick_id == ID_W'(N - 1)) ? '0 : pick_id + ID_W'(1);

   // A new arbitration round happens when idle, on early release, or on the last slice cycle.
   assign search = (state_q == IDLE) || !REQ[gnt_id_q] || (slice_left_q == SLICE_W'(1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         ptr_q        <= '0;
         gnt_q        <= '0;
         gnt_id_q     <= '0;
         gnt_vld_q    <= 1'b0;
         slice_left_q <= '0;
      end else begin
         case (state_q)
            IDLE, BUSY: begin
               if (search) begin
                  if (found) begin
                     state_q      <= BUSY;
                     ptr_q        <= ptr_d;
                     gnt_q        <= gnt_d;
                     gnt_id_q     <= pick_id;
                     gnt_vld_q    <= 1'b1;
                     slice_left_q <= slice_left_d;
                  end else begin
                     state_q      <= IDLE;
                     gnt_q        <= '0;
                     gnt_id_q     <= '0;
                     gnt_vld_q    <= 1'b0;
                     slice_left_q <= '0;
                  end
               end else begin
                  slice_left_q <= slice_left_q - SLICE_W'(1);
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign GNT        = gnt_q;
   assign GNT_ID     = gnt_id_q;
   assign GNT_VLD    = gnt_vld_q;
   assign SLICE_LEFT = slice_left_q;

endmodule

// File: tb/tb_round_robin_arbiter_param_slicing.sv
// tb/tb_round_robin_arbiter_param_slicing.sv - directed and random checks of the sliced round-robin arbiter
module tb_round_robin_arbiter_param_slicing;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [3:0]  req = 4'b0;
   logic [15:0] slen = 16'h0;
   logic [3:0]  gnt;
   logic [1:0]  gid;
   logic        vld;
   logic [3:0]  left;

   always #5 clk = ~clk;

   round_robin_arbiter_param_slicing #(.N(4), .SLICE_W(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .REQ        (req),
      .SLICE_LEN  (slen),
      .GNT        (gnt),
      .GNT_ID     (gid),
      .GNT_VLD    (vld),
      .SLICE_LEFT (left)
   );

   typedef struct packed {
      logic [3:0] g;
      logic [1:0] id;
      logic       v;
      logic [3:0] l;
   } obs_t;

   obs_t sb[$];
   int   total = 0;
   int   bad   = 0;

   bit   m_busy;
   int   m_id;
   int   m_left;
   int   m_ptr;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
         $error("check %s", tag);
      end
   endtask

   task automatic model_reset();
      m_busy = 1'b0;
      m_id   = 0;
      m_left = 0;
      m_ptr  = 0;
   endtask

   function automatic int field_of(input int i);
      logic [15:0] s;
      s = slen >> (i * 4);
      return int'(s[3:0]);
   endfunction

   task automatic model_step(input logic [3:0] r);
      logic [7:0] rot;
      bit         done;
      if (m_busy && r[m_id] && m_left > 1) begin
         m_left = m_left - 1;
      end else if (r == 4'b0) begin
         m_busy = 1'b0;
         m_id   = 0;
         m_left = 0;
      end else begin
         rot  = {r, r} >> m_ptr;
         done = 1'b0;
         for (int k = 0; k < 4; k++) begin
            if (!done && rot[k]) begin
               done = 1'b1;
               m_id = (m_ptr + k) % 4;
            end
         end
         m_left = (field_of(m_id) == 0) ? 1 : field_of(m_id);
         m_ptr  = (m_id + 1) % 4;
         m_busy = 1'b1;
      end
   endtask

   function automatic obs_t model_obs();
      obs_t e;
      e.g  = m_busy ? (4'b0001 << m_id) : 4'b0000;
      e.id = 2'(m_id);
      e.v  = m_busy;
      e.l  = 4'(m_left);
      return e;
   endfunction

   task automatic tick(input logic [3:0] r, input string tag);
      obs_t e;
      obs_t got;
      logic ok;
      req = r;
      model_step(r);
      sb.push_back(model_obs());
      @(posedge clk);
      #1;
      e   = sb.pop_front();
      got = {gnt, gid, vld, left};
      chk({tag, "_sb"}, 32'(got), 32'(e));
      ok = $onehot0(gnt) && (gnt == (vld ? (4'b0001 << gid) : 4'b0000)) && (vld || (gid == 2'd0));
      chk({tag, "_cons"}, 32'(ok), 32'd1);
   endtask

   task automatic expect_now(input string tag, input logic [3:0] g, input logic [1:0] id,
                             input logic v, input logic [3:0] l);
      chk(tag, 32'({gnt, gid, vld, left}), 32'({g, id, v, l}));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      expect_now("rst_async", 4'b0, 2'd0, 1'b0, 4'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      sb.delete();
   endtask

   initial begin
      int ids28 [12] = '{0, 0, 0, 0, 1, 1, 1, 2, 2, 3, 0, 0};
      int ids30 [6]  = '{0, 0, 3, 0, 0, 3};
      int left30 [6] = '{2, 1, 1, 2, 1, 1};

      rst = 1'b1;
      @(posedge clk);
      #1;
      expect_now("reset_state", 4'b0, 2'd0, 1'b0, 4'd0);
      rst = 1'b0;
      model_reset();

      // sole requester 3, slices of 3, renewed back-to-back
      slen = 16'h3333;
      tick(4'b1000, "r27a"); expect_now("r27_g3", 4'b1000, 2'd3, 1'b1, 4'd3);
      tick(4'b1000, "r27b"); expect_now("r27_l2", 4'b1000, 2'd3, 1'b1, 4'd2);
      tick(4'b1000, "r27c"); expect_now("r27_l1", 4'b1000, 2'd3, 1'b1, 4'd1);
      tick(4'b1000, "r27d"); expect_now("r27_renew", 4'b1000, 2'd3, 1'b1, 4'd3);
      tick(4'b0000, "r27e"); expect_now("r27_idle", 4'b0000, 2'd0, 1'b0, 4'd0);

      do_reset();
      slen = 16'h1234;
      for (int i = 0; i < 12; i++) begin
         tick(4'b1111, "r28");
         chk($sformatf("r28_id%0d", i), 32'(gid), 32'(ids28[i]));
      end

      do_reset();
      slen = 16'h4444;
      tick(4'b0110, "r29a"); expect_now("r29_g1", 4'b0010, 2'd1, 1'b1, 4'd4);
      tick(4'b0110, "r29b"); expect_now("r29_l3", 4'b0010, 2'd1, 1'b1, 4'd3);
      slen = 16'h1111;
      tick(4'b0100, "r29c"); expect_now("r29_g2", 4'b0100, 2'd2, 1'b1, 4'd1);
      slen = 16'h4444;

      do_reset();
      slen = 16'h0002;
      for (int i = 0; i < 6; i++) begin
         tick(4'b1001, "r30");
         chk($sformatf("r30_id%0d", i), 32'(gid), 32'(ids30[i]));
         chk($sformatf("r30_left%0d", i), 32'(left), 32'(left30[i]));
      end

      do_reset();
      slen = 16'h4444;
      for (int i = 0; i < 6; i++) begin
         tick(4'b1101, "r31");
      end
      expect_now("r31_pre", 4'b0100, 2'd2, 1'b1, 4'd3);
      #2;
      rst = 1'b1;
      #1;
      expect_now("r31_async", 4'b0, 2'd0, 1'b0, 4'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      tick(4'b1101, "r31b"); expect_now("r31_first", 4'b0001, 2'd0, 1'b1, 4'd4);

      do_reset();
      slen = 16'h2513;
      for (int i = 0; i < 400; i++) begin
         if (i % 9 == 0) begin
            slen = 16'($urandom);
         end
         if (i % 50 < 30) begin
            tick(4'($urandom_range(15, 0)) | 4'b0101, "rnd_hold");
         end else begin
            tick(4'($urandom_range(15, 0)), "rnd");
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/round_robin_arbiter_param_slicing.md
ROUND_ROBIN_ARBITER_PARAM_SLICING -- requirements
Module: round_robin_arbiter_param_slicing

Interface
REQ-001 Parameter N, default 4, number of requesters (2..16).
REQ-002 Parameter SLICE_W, default 4, width of each per-requester slice length field.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 REQ  input  N  request vector; bit i = requester i wants the resource.
REQ-006 SLICE_LEN  input  N*SLICE_W  packed per-requester quantum in cycles; field i = bits [i*SLICE_W +: SLICE_W].
REQ-007 GNT  output  N  registered one-hot grant, or all-zero when idle.
REQ-008 GNT_ID  output  max(1,clog2(N))  binary index of the granted requester; 0 when idle.
REQ-009 GNT_VLD  output  1  high when any GNT bit is set.
REQ-010 SLICE_LEFT  output  SLICE_W  cycles remaining in the current slice, including the current cycle; 0 when idle.

Function
REQ-011 The block SHALL be a two-state FSM: IDLE (no grant) and BUSY (one requester granted).
REQ-012 All outputs SHALL be registered; the decision uses REQ sampled at edge k, and GNT reflects it from edge k onward, one cycle after REQ is presented.
REQ-013 IDLE->BUSY when REQ != 0: grant the first set bit searching upward from PTR, wrapping N-1 -> 0.
REQ-014 PTR SHALL equal (last granted index + 1) mod N and SHALL update on every new grant.
REQ-015 On grant to i: SLICE_LEFT loads SLICE_LEN field i; a field value of 0 SHALL be treated as 1.
REQ-016 SLICE_LEN changes during a slice SHALL be ignored until the next grant or renewal.
REQ-017 In BUSY, while REQ[i] stays high and SLICE_LEFT > 1, GNT is held and SLICE_LEFT decrements by 1 per cycle.
REQ-018 Early release: if REQ[i] is low at an edge in BUSY, the current slice ends at that edge; the round-robin search from PTR runs in the same edge.
REQ-019 Expiry: at the edge where SLICE_LEFT == 1, the round-robin search from PTR runs.
REQ-020 For REQ-018 and REQ-019, a found requester is granted per REQ-015 with no idle gap; if REQ == 0, the FSM goes to IDLE.
REQ-021 If i is the only requester at expiry, the search returns i, and the slice SHALL be renewed back-to-back.
REQ-022 A requester granted once SHALL NOT be granted again while any other requester remains continuously asserted, until every such requester has received a slice (starvation freedom).
REQ-023 GNT SHALL never have more than one bit set; GNT_ID, GNT_VLD and GNT SHALL be mutually consistent every cycle.

Reset
REQ-024 While rst is high, asynchronously: GNT=0, GNT_ID=0, GNT_VLD=0, SLICE_LEFT=0, state=IDLE, PTR=0.
REQ-025 Reset asserted mid-slice SHALL abort the slice immediately.
REQ-026 The first grant after reset release SHALL follow REQ-013 with PTR=0, so requester 0 has highest priority.

Verification (N=4, SLICE_W=4)
REQ-027 Reset-release and idle check:
- Stimulus: SLICE_LEN all 3, REQ=4'b1000 held.
- Response: GNT=4'b1000 one cycle later, SLICE_LEFT 3,2,1, then the slice is renewed as 3 (sole requester).
REQ-028 Variable slices in rotation:
- Stimulus: SLICE_LEN={4'd1,4'd2,4'd3,4'd4} (field 3..0), REQ=4'b1111 held.
- Response: the grant sequence is 0 for 4 cycles, 1 for 3, 2 for 2, 3 for 1, then repeats from 0.
REQ-029 Early release:
- Stimulus: REQ=4'b0110, slice 4 each; drop REQ[1] during the second granted cycle.
- Response: GNT moves to 4'b0100 at the next edge, and SLICE_LEFT loads 4.
REQ-030 Zero-length field and wrap:
- Stimulus: SLICE_LEN[3] field=0, REQ=4'b1001 held.
- Response: grants alternate, with 3 held 1 cycle and 0 held its programmed length; PTR wraps 3->0.
REQ-031 Reset mid-slice:
- Stimulus: rst pulsed high during a grant to requester 2 with REQ=4'b1101.
- Response: outputs go to 0 without waiting for a clock; after release the first grant is to requester 0.
